// File: rtl/conv_stream_par.sv
// Streaming 1-D valid convolution: load M coefficients, then N samples, then
// P parallel MAC lanes produce y[0..L-1] in order with saturation and optional RELU.
//
// state   | meaning
// LOAD_F  | accepting M coefficients into the coefficient RAM
// LOAD_X  | accepting N samples into every lane's x-RAM copy
// PROCESS | lanes compute; results leave in order, lane n mod P
module conv_stream_par #(
    parameter int N    = 96,
    parameter int M    = 65,
    parameter int T    = 16,
    parameter int P    = 2,
    parameter int RELU = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] f_data,
    input  logic                f_valid,
    output logic                f_ready,
    input  logic signed [T-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [T-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready,
    input  logic                f_reload
);
    localparam int L  = N - M + 1;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (M > 1) ? $clog2(M) : 1;
    localparam int NW = $clog2(N + P + 1);
    localparam int KW = $clog2(M + 1);
    localparam int XW = $clog2(N + 1);
    localparam int OW = $clog2(L + 1);
    localparam int SW = (P > 1) ? $clog2(P) : 1;

    localparam logic [NW-1:0] L_N    = NW'(L);
    localparam logic [NW-1:0] P_N    = NW'(P);
    localparam logic [KW-1:0] K_LAST = KW'(M - 1);
    localparam logic [XW-1:0] X_LAST = XW'(N - 1);
    localparam logic [OW-1:0] O_LAST = OW'(L - 1);
    localparam logic [SW-1:0] S_LAST = SW'(P - 1);
    localparam logic signed [T-1:0] S_MAX = {1'b0, {(T-1){1'b1}}};
    localparam logic signed [T-1:0] S_MIN = {1'b1, {(T-1){1'b0}}};

    typedef enum logic [1:0] {LOAD_F, LOAD_X, PROCESS} state_t;

    state_t              r_state;
    logic                r_f_ready, r_x_ready;
    logic [KW-1:0]       r_f_cnt;
    logic [XW-1:0]       r_x_cnt;
    logic [OW-1:0]       r_out_cnt;
    logic [SW-1:0]       r_sel;
    logic signed [T-1:0] r_f_mem [M];
    logic signed [T-1:0] r_x_mem [P][N];

    logic [NW-1:0]       r_n          [P];
    logic [KW-1:0]       r_k          [P];
    logic signed [T-1:0] r_prod       [P];
    logic                r_prod_v     [P];
    logic                r_prod_first [P];
    logic                r_prod_last  [P];
    logic signed [T-1:0] r_acc        [P];
    logic signed [T-1:0] r_res        [P];
    logic                r_res_v      [P];

    logic                  w_f_fire, w_x_fire, w_y_fire, w_frame_done;
    logic                  w_issue   [P];
    logic                  w_consume [P];
    logic [AW-1:0]         w_xidx    [P];
    logic signed [2*T-1:0] w_mul     [P];
    logic signed [T:0]     w_sum     [P];
    logic signed [T-1:0]   w_prod    [P];
    logic signed [T-1:0]   w_acc     [P];
    logic signed [T-1:0]   w_res     [P];

    assign w_f_fire     = f_valid && r_f_ready;
    assign w_x_fire     = x_valid && r_x_ready;
    assign w_y_fire     = y_valid && y_ready;
    assign w_frame_done = w_y_fire && (r_out_cnt == O_LAST);

    assign f_ready = r_f_ready;
    assign x_ready = r_x_ready;
    assign y_valid = r_res_v[r_sel];
    assign y_data  = r_res[r_sel];

    always_comb begin
        for (int l = 0; l < P; l++) begin
            w_consume[l] = y_ready && r_res_v[l] && (r_sel == SW'(l));
            // The last product may only be issued if the result slot is free
            // by the time that product finishes accumulating.
            w_issue[l] = (r_state == PROCESS) && (r_n[l] < L_N) &&
                         !((r_k[l] == K_LAST) &&
                           ((r_res_v[l] && !w_consume[l]) || (r_prod_v[l] && r_prod_last[l])));
            w_xidx[l] = AW'(r_n[l] + NW'(r_k[l]));
            w_mul[l]  = r_x_mem[l][w_xidx[l]] * r_f_mem[FW'(r_k[l])];
            if (w_mul[l][2*T-1:T-1] == '0 || w_mul[l][2*T-1:T-1] == '1)
                w_prod[l] = w_mul[l][T-1:0];
            else
                w_prod[l] = w_mul[l][2*T-1] ? S_MIN : S_MAX;
            w_sum[l] = {r_acc[l][T-1], r_acc[l]} + {r_prod[l][T-1], r_prod[l]};
            if (r_prod_first[l])
                w_acc[l] = r_prod[l];
            else if (w_sum[l][T] != w_sum[l][T-1])
                w_acc[l] = w_sum[l][T] ? S_MIN : S_MAX;
            else
                w_acc[l] = w_sum[l][T-1:0];
            w_res[l] = (RELU != 0 && w_acc[l][T-1]) ? '0 : w_acc[l];
        end
    end

    always_ff @(posedge clk) begin
        if (w_f_fire)
            r_f_mem[FW'(r_f_cnt)] <= f_data;
        if (w_x_fire)
            for (int l = 0; l < P; l++)
                r_x_mem[l][AW'(r_x_cnt)] <= x_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= LOAD_F;
            r_f_ready <= 1'b1;
            r_x_ready <= 1'b0;
            r_f_cnt   <= '0;
            r_x_cnt   <= '0;
            r_out_cnt <= '0;
            r_sel     <= '0;
        end else begin
            case (r_state)
                LOAD_F: if (w_f_fire) begin
                    if (r_f_cnt == K_LAST) begin
                        r_f_cnt   <= '0;
                        r_f_ready <= 1'b0;
                        r_x_ready <= 1'b1;
                        r_state   <= LOAD_X;
                    end else
                        r_f_cnt <= r_f_cnt + 1'b1;
                end
                LOAD_X: if (w_x_fire) begin
                    if (r_x_cnt == X_LAST) begin
                        r_x_cnt   <= '0;
                        r_x_ready <= 1'b0;
                        r_state   <= PROCESS;
                    end else
                        r_x_cnt <= r_x_cnt + 1'b1;
                end
                PROCESS: if (w_y_fire) begin
                    r_sel <= (r_sel == S_LAST) ? '0 : r_sel + 1'b1;
                    if (w_frame_done) begin
                        r_out_cnt <= '0;
                        r_sel     <= '0;
                        if (f_reload) begin
                            r_state   <= LOAD_F;
                            r_f_ready <= 1'b1;
                        end else begin
                            r_state   <= LOAD_X;
                            r_x_ready <= 1'b1;
                        end
                    end else
                        r_out_cnt <= r_out_cnt + 1'b1;
                end
                default: r_state <= LOAD_F;
            endcase
        end
    end

    // Lane l owns outputs l, l+P, l+2P, ...; product stage then accumulate stage.
    always_ff @(posedge clk) begin
        for (int l = 0; l < P; l++) begin
            if (reset || w_frame_done) begin
                r_n[l]          <= NW'(l);
                r_k[l]          <= '0;
                r_prod[l]       <= '0;
                r_prod_v[l]     <= 1'b0;
                r_prod_first[l] <= 1'b0;
                r_prod_last[l]  <= 1'b0;
                r_acc[l]        <= '0;
                r_res_v[l]      <= 1'b0;
                if (reset)
                    r_res[l] <= '0;
            end else begin
                r_prod_v[l] <= w_issue[l];
                if (w_issue[l]) begin
                    r_prod[l]       <= w_prod[l];
                    r_prod_first[l] <= (r_k[l] == '0);
                    r_prod_last[l]  <= (r_k[l] == K_LAST);
                    if (r_k[l] == K_LAST) begin
                        r_k[l] <= '0;
                        r_n[l] <= r_n[l] + P_N;
                    end else
                        r_k[l] <= r_k[l] + 1'b1;
                end
                if (w_consume[l])
                    r_res_v[l] <= 1'b0;
                if (r_prod_v[l]) begin
                    r_acc[l] <= w_acc[l];
                    if (r_prod_last[l]) begin
                        r_res[l]   <= w_res[l];
                        r_res_v[l] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/conv_stream_par.md
CONV_STREAM_PAR -- requirements
Module: conv_stream_par

Interface
REQ-001 SHALL have parameter N, default 96, meaning input frame length (x samples per frame).
REQ-002 SHALL have parameter M, default 65, meaning filter length; M<=N.
REQ-003 SHALL have parameter T, default 16, meaning signed sample/coefficient/result width.
REQ-004 SHALL have parameter P, default 2, meaning parallel MAC lanes; 1<=P<=L, where L=N-M+1.
REQ-005 SHALL have parameter RELU, default 1, meaning 1 clamps negative results to 0 and 0 passes signed results.
REQ-006 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port f_data  input  T  signed coefficient stream, f[0] first.
REQ-009 SHALL have ports f_valid  input  1  and f_ready  output  1  forming the coefficient handshake.
REQ-010 SHALL have port x_data  input  T  signed sample stream, x[0] first.
REQ-011 SHALL have ports x_valid  input  1  and x_ready  output  1  forming the sample handshake.
REQ-012 SHALL have port y_data  output  T  result stream, y[0] first.
REQ-013 SHALL have ports y_valid  output  1  and y_ready  input  1  forming the result handshake.
REQ-014 SHALL have port f_reload  input  1  request to reload coefficients at the next frame boundary.

Function
REQ-015 SHALL transfer on any stream only in a cycle where valid and ready are both 1.
REQ-016 SHALL implement a top FSM with states LOAD_F, LOAD_X and PROCESS.
REQ-017 SHALL assert f_ready only in LOAD_F, accept exactly M coefficients into a writable coefficient RAM, then go to LOAD_X.
REQ-018 SHALL assert x_ready only in LOAD_X while fewer than N samples are accepted, then go to PROCESS after the Nth sample.
REQ-019 SHALL compute y[n]=sum over k=0..M-1 of x[n+k]*f[k], for n=0..L-1.
REQ-020 SHALL assign output n to lane n mod P, with each lane stepping its outer index by P.
REQ-021 SHALL emit outputs strictly in order y[0]..y[L-1], selecting lanes round-robin starting at lane 0.
REQ-022 SHALL run every lane in parallel from its own x-RAM copy, all copies written during LOAD_X.
REQ-023 SHALL saturate each product to [-2^(T-1), 2^(T-1)-1] and register it (one pipeline stage).
REQ-024 SHALL saturate the accumulator to the same range after every addition, with no wrap-around ever visible.
REQ-025 SHALL apply RELU to the final result: when RELU=1, a negative accumulator gives y_data=0.
REQ-026 SHALL assert the first y_valid of a frame no more than M+4 cycles after the last x transfer.
REQ-027 SHALL hold y_valid and y_data stable until y_ready is 1; a lane whose result waits stalls only that lane.
REQ-028 SHALL, after y[L-1] transfers, go to LOAD_F if f_reload was 1 in that cycle, else to LOAD_X; coefficients persist otherwise.
REQ-029 SHALL leave x_ready and f_ready low in PROCESS, with no bubbles required between frames other than the FSM transition.

Reset
REQ-030 SHALL, on reset, enter LOAD_F, clear all counters and accumulators, and drive f_ready=1, x_ready=0, y_valid=0, y_data=0.
REQ-031 SHALL let reset asserted mid-load or mid-process abandon the frame; no partial y is emitted afterwards, and coefficients must be reloaded.

Verification
REQ-032 SHALL pass this case: N=8,M=3,P=1,f={1,1,1}, x=0..7 -> y={3,6,9,12,15,18}, in order.
REQ-033 SHALL pass this case: default parameters, random x and f, y_ready toggled randomly -> all 32 y match a saturating/RELU golden model, and lanes alternate 0,1.
REQ-034 SHALL pass this case: T=16, x all 32767, f all 32767 -> every y=32767; with f all -32768 and RELU=1 -> every y=0; with RELU=0 -> every y=-32768.
REQ-035 SHALL pass this case: two back-to-back frames with f_reload=0, then a third frame with f_reload=1 and new f -> frame 3 uses the new f, and f_ready is never high during frames 1-2.
REQ-036 SHALL pass this case: reset pulsed after 40 of 96 x samples -> y_valid stays 0, f_ready=1 next cycle, and a full reload gives correct results.
REQ-037 SHALL pass this case: gapped x_valid (1 in 3 cycles) and y_ready held 0 for 50 cycles -> no sample is lost or duplicated, and y_data is stable while stalled.
